multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle main controller that sequences the shared single-port datapath: one memory port serves both instruction fetch and load/store, and one ALU serves PC increment, address generation, branch compare and execute. It replaces the single-cycle decode path. It walks each instruction through FETCH/DECODE/execute/writeback states and drives every datapath mux and enable. It stalls on a memory ready handshake.

## Interface
Parameters:
- RETIRE_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  5  instruction bits [23:19] from the instruction register
- zero  in  1  ALU zero flag, combinational from datapath
- mem_ready  in  1  memory completes the current read/write this cycle
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- irwrite  out  1  load instruction register
- pcen  out  1  PC load enable (pcwrite | (branch & zero))
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alusrca  out  1  0=PC, 1=reg A
- alusrcb  out  2  00=reg B, 01=const 4, 10=signimm, 11=signimm<<2
- alucontrol  out  3  ADD 010, SUB 110, AND 000, OR 001, SLT 111
- regwrite  out  1  register file write enable
- regdst  out  1  0=rt, 1=rd
- memtoreg  out  1  0=ALUOut, 1=memory data register
- illegal  out  1  one-cycle pulse on an undefined opcode
- instr_done  out  1  one-cycle pulse on an instruction's final state
- retired  out  RETIRE_W  count of instr_done pulses, wraps

## Operation
- Opcodes: ADD 00000, SUB 00001, AND 00010, OR 00011, SLT 00100 (R-type); ADDI 01000; LW 10000; SW 10001; BEQ 11000; J 11100. All others are illegal.
- opcode is latched into op_q in DECODE. Later states use op_q only.
- Outputs are a Moore decode of state, except pcen, which also uses zero. Outputs not listed for a state are 0.
- FETCH: memread, iord=0, alusrca=0, alusrcb=01, ADD. Hold until mem_ready. On the mem_ready cycle also assert irwrite and pcen (pcsrc=00), then go to DECODE.
- DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut). Next state:
  - LW/SW → MEMADR
  - R-type → EXECUTE
  - ADDI → ADDIEX
  - BEQ → BRANCH
  - J → JUMP
  - else → ILLEGAL
- MEMADR: alusrca=1, alusrcb=10, ADD. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: memread, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regwrite, regdst=0, memtoreg=1, instr_done. Then FETCH.
- MEMWR: memwrite, iord=1. Hold until mem_ready. The mem_ready cycle asserts instr_done, then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from op_q. Then ALUWB.
- ALUWB: regwrite, regdst=1, memtoreg=0, instr_done. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, ADD. Then ADDIWB.
- ADDIWB: regwrite, regdst=0, instr_done. Then FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero, instr_done. Then FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done. Then FETCH.
- ILLEGAL: illegal=1, instr_done=0. Then FETCH. The PC has already advanced, so the bad word is skipped.
- retired increments on every instr_done and wraps from all-ones to 0.

## Timing
- Reset asserted:
  - state=FETCH, op_q=0, retired=0.
  - All control outputs are forced to 0 combinationally, even though state is FETCH.
  - A pending memwrite drops in the same cycle reset rises; no partial write is held.
- The first FETCH request appears in the first cycle after reset deasserts.
- mem_ready may be high in the same cycle a request is raised; that is a zero-wait access.
- mem_ready is ignored in states that make no memory request.
- Memory request signals stay stable while waiting; no state change occurs without mem_ready.
- Cycles per instruction, zero-wait memory: LW 5; SW 4; R-type 4; ADDI 4; BEQ 3; J 3; illegal 3.
- Each wait cycle on a memory access adds 1.
- Back-to-back: the cycle after any final state is FETCH. There are no idle cycles.

## Structure
- Package mc_pkg holds:
  - opcode constants
  - alucontrol codes
  - alusrcb and pcsrc encodings
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, ILLEGAL
- Sub-module mc_aludec maps op_q to alucontrol for EXECUTE. It is purely combinational.
- The FSM, output decode and retire counter live in multicycle_ctrl.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 and opcode=ADD:
  - all outputs 0 during reset
  - cycle 1: memread=1, irwrite=1, pcen=1
  - instr_done on cycle 4; retired=1
- LW with mem_ready delayed 2 cycles in both FETCH and MEMRD:
  - memread held for 3 cycles each time
  - MEMWB has regwrite=1, memtoreg=1, regdst=0
  - total 9 cycles
- BEQ with zero=1 vs zero=0:
  - in BRANCH, pcen=1 and pcsrc=01 when zero=1; pcen=0 when zero=0
  - alucontrol=110 in both cases
  - 3 cycles each
- SW with reset asserted while waiting in MEMWR:
  - memwrite falls in the same cycle
  - state returns to FETCH and retired=0
- Opcode 11111:
  - illegal pulses for exactly 1 cycle in the 3rd cycle
  - instr_done=0 and retired unchanged
  - next FETCH follows immediately
- SLT then J:
  - EXECUTE alucontrol=111; ALUWB regdst=1
  - JUMP pcsrc=10, pcen=1
  - retired increments by 2

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle controller.
// Opcodes, ALU codes, mux selects and the FSM state type.
package mc_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SLT  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_LW   = 5'b10000;
    localparam logic [4:0] OP_SW   = 5'b10001;
    localparam logic [4:0] OP_BEQ  = 5'b11000;
    localparam logic [4:0] OP_J    = 5'b11100;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        ADDIEX,
        ADDIWB,
        BRANCH,
        JUMP,
        ILLEGAL
    } state_t;

    function automatic logic is_rtype(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: R-type opcode to ALU operation.
// Purely combinational; non-R-type codes fall back to ADD.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [4:0] op,
    output logic [2:0] alucontrol
);

    // Map the latched R-type opcode to its ALU function
    always_comb begin
        alucontrol = ALU_ADD;
        case (op)
            OP_ADD:  alucontrol = ALU_ADD;
            OP_SUB:  alucontrol = ALU_SUB;
            OP_AND:  alucontrol = ALU_AND;
            OP_OR:   alucontrol = ALU_OR;
            OP_SLT:  alucontrol = ALU_SLT;
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM for the shared-port multicycle datapath.
// Sequences fetch/decode/execute/writeback and counts retirements.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                memread,
    output logic                memwrite,
    output logic                iord,
    output logic                irwrite,
    output logic                pcen,
    output logic [1:0]          pcsrc,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [2:0]          alucontrol,
    output logic                regwrite,
    output logic                regdst,
    output logic                memtoreg,
    output logic                illegal,
    output logic                instr_done,
    output logic [RETIRE_W-1:0] retired
);

    state_t     state;
    state_t     next;
    logic [4:0] op_q;
    logic [2:0] alu_ex;
    logic       pcwrite;
    logic       branch;

    mc_aludec u_aludec (
        .op         (op_q),
        .alucontrol (alu_ex)
    );

    // Next-state selection; memory states wait on mem_ready
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:   next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)
                    next = MEMADR;
                else if (is_rtype(opcode))
                    next = EXECUTE;
                else if (opcode == OP_ADDI)
                    next = ADDIEX;
                else if (opcode == OP_BEQ)
                    next = BRANCH;
                else if (opcode == OP_J)
                    next = JUMP;
                else
                    next = ILLEGAL;
            end
            MEMADR:  next = (op_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next = mem_ready ? MEMWB : MEMRD;
            MEMWB:   next = FETCH;
            MEMWR:   next = mem_ready ? FETCH : MEMWR;
            EXECUTE: next = ALUWB;
            ALUWB:   next = FETCH;
            ADDIEX:  next = ADDIWB;
            ADDIWB:  next = FETCH;
            BRANCH:  next = FETCH;
            JUMP:    next = FETCH;
            ILLEGAL: next = FETCH;
            default: next = FETCH;
        endcase
    end

    // Moore output decode, held at zero while reset is high
    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        pcsrc      = PC_ALU;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        alucontrol = ALU_AND;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    memread    = 1'b1;
                    alusrcb    = SRCB_FOUR;
                    alucontrol = ALU_ADD;
                    irwrite    = mem_ready;
                    pcwrite    = mem_ready;
                end
                DECODE: begin
                    alusrcb    = SRCB_IMMSH;
                    alucontrol = ALU_ADD;
                end
                MEMADR: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_IMM;
                    alucontrol = ALU_ADD;
                end
                MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWR: begin
                    memwrite   = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                EXECUTE: begin
                    alusrca    = 1'b1;
                    alucontrol = alu_ex;
                end
                ALUWB: begin
                    regwrite   = 1'b1;
                    regdst     = 1'b1;
                    instr_done = 1'b1;
                end
                ADDIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_IMM;
                    alucontrol = ALU_ADD;
                end
                ADDIWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = PC_ALUOUT;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                JUMP: begin
                    pcsrc      = PC_JUMP;
                    pcwrite    = 1'b1;
                    instr_done = 1'b1;
                end
                ILLEGAL: illegal = 1'b1;
                default: ;
            endcase
        end
        pcen = pcwrite | (branch & zero);
    end

    // State, latched opcode and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            op_q    <= '0;
            retired <= '0;
        end else begin
            state <= next;
            if (state == DECODE)
                op_q <= opcode;
            if (instr_done)
                retired <= retired + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vectors for the multicycle controller.
// Expected values are hand-derived per cycle of each instruction.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        memread;
    logic        memwrite;
    logic        iord;
    logic        irwrite;
    logic        pcen;
    logic [1:0]  pcsrc;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [2:0]  alucontrol;
    logic        regwrite;
    logic        regdst;
    logic        memtoreg;
    logic        illegal;
    logic        instr_done;
    logic [31:0] retired;

    int n_pass = 0;
    int n_total = 0;
    int n;

    multicycle_ctrl #(.RETIRE_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .memread    (memread),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .illegal    (illegal),
        .instr_done (instr_done),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    wire any_out = memread | memwrite | iord | irwrite | pcen |
                   (|pcsrc) | alusrca | (|alusrcb) | (|alucontrol) |
                   regwrite | regdst | memtoreg | illegal | instr_done;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        n++;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 5'b00000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("rst_outs", 32'(any_out), 0);
            chk("rst_retired", retired, 0);
            step();
        end
        reset = 1'b0;

        // ADD with zero-wait memory
        #2;
        chk("add_c1_memread", 32'(memread), 1);
        chk("add_c1_irwrite", 32'(irwrite), 1);
        chk("add_c1_pcen", 32'(pcen), 1);
        chk("add_c1_srcb", 32'(alusrcb), 1);
        step();
        #2;
        chk("add_c2_srcb", 32'(alusrcb), 3);
        chk("add_c2_done", 32'(instr_done), 0);
        step();
        #2;
        chk("add_c3_alu", 32'(alucontrol), 3'b010);
        chk("add_c3_srca", 32'(alusrca), 1);
        step();
        #2;
        chk("add_c4_done", 32'(instr_done), 1);
        chk("add_c4_regdst", 32'(regdst), 1);
        step();
        #2;
        chk("add_retired", retired, 1);

        // LW with two wait cycles in FETCH and MEMRD
        n = 0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #2;
            chk("lw_f_memread", 32'(memread), 1);
            chk("lw_f_irwrite", 32'(irwrite), 32'(i == 2));
            step();
        end
        mem_ready = 1'b0;
        opcode = 5'b10000;
        #2;
        chk("lw_dec_srcb", 32'(alusrcb), 3);
        step();
        opcode = 5'b00000;
        #2;
        chk("lw_adr_srca", 32'(alusrca), 1);
        chk("lw_adr_srcb", 32'(alusrcb), 2);
        step();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #2;
            chk("lw_rd_memread", 32'(memread), 1);
            chk("lw_rd_iord", 32'(iord), 1);
            step();
        end
        mem_ready = 1'b0;
        #2;
        chk("lw_wb_regwrite", 32'(regwrite), 1);
        chk("lw_wb_memtoreg", 32'(memtoreg), 1);
        chk("lw_wb_regdst", 32'(regdst), 0);
        chk("lw_wb_done", 32'(instr_done), 1);
        step();
        chk("lw_cycles", n, 9);
        chk("lw_retired", retired, 2);

        // BEQ taken then not taken
        for (int z = 1; z >= 0; z--) begin
            n = 0;
            mem_ready = 1'b1;
            zero = 1'b0;
            step();
            opcode = 5'b11000;
            step();
            zero = 1'(z);
            #2;
            chk("beq_pcen", 32'(pcen), 32'(z));
            chk("beq_pcsrc", 32'(pcsrc), 1);
            chk("beq_alu", 32'(alucontrol), 3'b110);
            chk("beq_done", 32'(instr_done), 1);
            step();
            chk("beq_cycles", n, 3);
        end
        zero = 1'b0;
        chk("beq_retired", retired, 4);

        // undefined opcode 11111
        step();
        opcode = 5'b11111;
        #2;
        chk("ill_dec", 32'(illegal), 0);
        step();
        #2;
        chk("ill_pulse", 32'(illegal), 1);
        chk("ill_done", 32'(instr_done), 0);
        step();
        #2;
        chk("ill_after", 32'(illegal), 0);
        chk("ill_fetch", 32'(memread), 1);
        chk("ill_retired", retired, 4);

        // SLT then J (FETCH already current)
        opcode = 5'b00100;
        step();
        step();
        opcode = 5'b00000;
        #2;
        chk("slt_alu", 32'(alucontrol), 3'b111);
        step();
        #2;
        chk("slt_regdst", 32'(regdst), 1);
        chk("slt_regwrite", 32'(regwrite), 1);
        chk("slt_done", 32'(instr_done), 1);
        step();
        step();
        opcode = 5'b11100;
        step();
        #2;
        chk("j_pcsrc", 32'(pcsrc), 2);
        chk("j_pcen", 32'(pcen), 1);
        chk("j_done", 32'(instr_done), 1);
        step();
        chk("slt_j_retired", retired, 6);

        // SW interrupted by reset while waiting
        step();
        opcode = 5'b10001;
        step();
        step();
        mem_ready = 1'b0;
        #2;
        chk("sw_memwrite", 32'(memwrite), 1);
        step();
        #2;
        chk("sw_hold", 32'(memwrite), 1);
        chk("sw_iord", 32'(iord), 1);
        reset = 1'b1;
        #1;
        chk("sw_rst_memwrite", 32'(memwrite), 0);
        chk("sw_rst_outs", 32'(any_out), 0);
        chk("sw_rst_retired", retired, 0);
        step();
        reset = 1'b0;
        #2;
        chk("sw_rst_fetch", 32'(memread), 1);
        chk("sw_rst_retired2", retired, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
